// File: rtl/tdm_demux4_to_1.sv
// Receive-side TDM demultiplexer: tracks slot position in a 4-slot frame and
// presents completed frames on four parallel channel outputs.
module tdm_demux4_to_1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic             sync_err,
  output logic             locked,
  output logic             s1,
  output logic             s0,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d, hold2_q, hold2_d;
  logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    hold0_d       = hold0_q;
    hold1_d       = hold1_q;
    hold2_d       = hold2_q;
    out0_d        = out0_q;
    out1_d        = out1_q;
    out2_d        = out2_q;
    out3_d        = out3_q;
    out_valid_d   = 1'b0;
    sync_err_d    = 1'b0;
    frame_count_d = frame_count_q;
    if (in_valid) begin
      if (state_q == HUNT) begin
        if (in_sync) begin
          hold0_d = in_data;
          slot_d  = 2'd1;
          state_d = LOCKED;
        end
      end else if (in_sync) begin
        // Sync anywhere but slot 0 drops the partial frame and restarts it here.
        sync_err_d = (slot_q != 2'd0);
        hold0_d    = in_data;
        slot_d     = 2'd1;
      end else begin
        unique case (slot_q)
          2'd0: begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end
          2'd1: begin
            hold1_d = in_data;
            slot_d  = 2'd2;
          end
          2'd2: begin
            hold2_d = in_data;
            slot_d  = 2'd3;
          end
          default: begin
            out0_d        = hold0_q;
            out1_d        = hold1_q;
            out2_d        = hold2_q;
            out3_d        = in_data;
            out_valid_d   = 1'b1;
            frame_count_d = frame_count_q + 1'b1;
            slot_d        = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      hold0_q       <= '0;
      hold1_q       <= '0;
      hold2_q       <= '0;
      out0_q        <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      out3_q        <= '0;
      out_valid_q   <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      hold0_q       <= hold0_d;
      hold1_q       <= hold1_d;
      hold2_q       <= hold2_d;
      out0_q        <= out0_d;
      out1_q        <= out1_d;
      out2_q        <= out2_d;
      out3_q        <= out3_d;
      out_valid_q   <= out_valid_d;
      sync_err_q    <= sync_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign out_valid   = out_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign s1          = slot_q[1];
  assign s0          = slot_q[0];
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tdm_demux4_to_1.sv
// Scoreboard bench for tdm_demux4_to_1: expected frames are queued as the last
// word of each frame is driven and compared whenever out_valid is seen.
module tb_tdm_demux4_to_1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sync = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] out0, out1, out2, out3, frame_count;
  logic       out_valid, sync_err, locked, s1, s0;

  tdm_demux4_to_1 #(.WIDTH(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sync(in_sync),
    .in_data(in_data), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .sync_err(sync_err), .locked(locked),
    .s1(s1), .s0(s0), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] o0, o1, o2, o3, fc;
  } frame_t;

  frame_t     sb[$];
  logic [7:0] exp_fc = '0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         serr_cnt = 0;
  int         cyc = 0;
  int         last_valid = -1;
  bit         cadence_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (out_valid && sync_err) chk("valid_and_err", 1, 0);
    if (sync_err) serr_cnt++;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        frame_t e;
        e = sb.pop_front();
        chk("sb_out0", out0, e.o0);
        chk("sb_out1", out1, e.o1);
        chk("sb_out2", out2, e.o2);
        chk("sb_out3", out3, e.o3);
        chk("sb_fc", frame_count, e.fc);
      end
      if (cadence_on && last_valid >= 0) chk("cadence", cyc - last_valid, 4);
      last_valid = cyc;
    end
  end

  task automatic send(input logic [7:0] d, input logic s);
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = d; in_sync = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      in_valid = 1'b0; in_sync = 1'b0; in_data = 8'hxx;
    end
  endtask

  task automatic push(input logic [7:0] a, b, c, d);
    exp_fc = exp_fc + 8'd1;
    sb.push_back({a, b, c, d, exp_fc});
  endtask

  task automatic send_frame(input logic [7:0] a, b, c, d);
    send(a, 1'b1); send(b, 1'b0); send(c, 1'b0);
    push(a, b, c, d);
    send(d, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_outs"}, {out0, out1, out2, out3}, 0);
    chk({tag, "_fc"}, frame_count, 0);
    chk({tag, "_flags"}, {out_valid, sync_err, locked, s1, s0}, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    in_valid = 1'b0; in_sync = 1'b0; reset = 1'b1;
    #2;
    chk_reset_state("rst");
    @(negedge clock); reset = 1'b0;
    exp_fc = '0;
  endtask

  initial begin
    int e0;
    logic [7:0] r [4];
    repeat (2) @(posedge clock);
    #1 chk_reset_state("por");
    @(negedge clock); reset = 1'b0;

    // 1: back-to-back frame with latency check
    send_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    idle(1);
    chk("t1_valid", out_valid, 1);
    chk("t1_outs", {out0, out1, out2, out3}, 32'hA1B2C3D4);
    chk("t1_state", {frame_count, locked, s1, s0}, {8'd1, 3'b100});
    idle(1);
    chk("t1_valid_drop", out_valid, 0);

    // 2: gaps between words
    send(8'hA1, 1'b1); idle(1); chk("t2_slot1", {s1, s0}, 1);
    send(8'hB2, 1'b0); idle(2); chk("t2_slot2", {s1, s0}, 2); chk("t2_novalid", out_valid, 0);
    send(8'hC3, 1'b0); idle(3); chk("t2_slot3", {s1, s0}, 3);
    push(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    send(8'hD4, 1'b0); idle(1);
    chk("t2_valid", out_valid, 1);
    chk("t2_fc", frame_count, 2);
    idle(2);

    // 3: early sync discards partial frame
    do_reset();
    e0 = serr_cnt;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44);
    send(8'h55, 1'b1); send(8'h66, 1'b0);
    send(8'h77, 1'b1); idle(1);
    chk("t3_serr_pulse", sync_err, 1);
    chk("t3_outs_held", {out0, out1, out2, out3}, 32'h11223344);
    chk("t3_slot", {locked, s1, s0}, 3'b101);
    send(8'h88, 1'b0); send(8'h99, 1'b0);
    push(8'h77, 8'h88, 8'h99, 8'hAA);
    send(8'hAA, 1'b0); idle(2);
    chk("t3_serr_count", serr_cnt - e0, 1);
    chk("t3_fc", frame_count, 2);

    // 4: missing sync at slot 0 drops lock
    e0 = serr_cnt;
    send(8'h5A, 1'b0); idle(1);
    chk("t4_serr", sync_err, 1);
    chk("t4_unlocked", {locked, s1, s0}, 0);
    chk("t4_outs_held", {out0, out1, out2, out3}, 32'h778899AA);
    send(8'h01, 1'b0); send(8'h02, 1'b0); idle(1);
    chk("t4_hunt_quiet", serr_cnt - e0, 1);
    chk("t4_still_hunt", locked, 0);
    send_frame(8'h10, 8'h20, 8'h30, 8'h40);
    idle(2);
    chk("t4_relocked", locked, 1);

    // 5: 256 back-to-back frames wrap frame_count
    do_reset();
    last_valid = -1; cadence_on = 1'b1;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 4; k++) r[k] = 8'($urandom);
      send_frame(r[0], r[1], r[2], r[3]);
    end
    idle(2);
    cadence_on = 1'b0;
    chk("t5_fc_wrap", frame_count, 0);

    // 6: reset mid-frame
    send(8'hA1, 1'b1); send(8'hB2, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b0; reset = 1'b1;
    #2 chk_reset_state("t6");
    @(negedge clock); reset = 1'b0; exp_fc = '0;
    send_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    idle(1);
    chk("t6_fresh", {out0, out1, out2, out3, frame_count}, {32'hC1C2C3C4, 8'd1});

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    idle(2);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4_to_1.md
Name: tdm_demux4_to_1

Overview:
- Receive-end counterpart of the 4-to-1 channel multiplexer.
- Accepts a time-division-multiplexed word stream in which slots 0..3 carry channels IN0..IN3 and a sync flag marks slot 0.
- Tracks slot position with a 2-bit slot counter and writes each word to its channel holding register.
- Presents all four channels in parallel, with a one-cycle valid pulse, once a full frame has arrived.

Parameters:
- WIDTH, 8: bits per slot word and per channel output.
- CNT_W, 8: width of the completed-frame counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_sync are sampled this cycle.
- in_sync  input  1  marks the current word as slot 0. Meaningful only with in_valid.
- in_data  input  WIDTH  slot word.
- out0  output  WIDTH  channel 0 word of the last complete frame.
- out1  output  WIDTH  channel 1 word of the last complete frame.
- out2  output  WIDTH  channel 2 word of the last complete frame.
- out3  output  WIDTH  channel 3 word of the last complete frame.
- out_valid  output  1  one-cycle pulse when out0..out3 update.
- sync_err  output  1  one-cycle pulse on a framing error.
- locked  output  1  high while the FSM is in LOCKED.
- s1, s0  output  1 each  current slot counter (expected slot of the next word).
- frame_count  output  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, active-high):
  - out0..out3, holding registers, frame_count all 0.
  - out_valid, sync_err, locked = 0; {s1,s0} = 0; state HUNT.
  - Deassertion is synchronous to clock.
- All outputs are registered and update on the rising clock edge.
- A cycle with in_valid=0 changes nothing: gaps between words are legal, and out_valid/sync_err stay 0.
- FSM states: HUNT, LOCKED.
- HUNT:
  - in_valid=1, in_sync=0: word discarded, no error.
  - in_valid=1, in_sync=1: hold0 <= in_data, {s1,s0} <= 1, go to LOCKED.
- LOCKED, in_valid=1, with slot = {s1,s0}:
  - slot=0, in_sync=1: hold0 <= in_data, slot <= 1.
  - slot=0, in_sync=0 (missing sync): word discarded, sync_err pulses, go to HUNT, slot stays 0. out0..out3 keep their values.
  - slot in 1..2, in_sync=0: hold[slot] <= in_data, slot <= slot+1.
  - slot=3, in_sync=0 (frame complete), all on the same edge:
    - out0..out2 <= hold0..hold2 and out3 <= in_data.
    - out_valid <= 1 for one cycle.
    - frame_count <= frame_count+1.
    - slot wraps to 0.
  - slot in 1..3, in_sync=1 (early sync): the partial frame is discarded and out0..out3 are unchanged. sync_err pulses, hold0 <= in_data, slot <= 1, FSM stays LOCKED.
- Latency: out_valid is high in the cycle immediately after the edge that samples slot 3.
- out_valid and sync_err are never high in the same cycle.
- Back-to-back frames with no gaps are supported, giving out_valid every 4th cycle.
- out0..out3 hold their values indefinitely between frames.
- frame_count wraps from 2^CNT_W-1 to 0 without a flag.
- locked = (state == LOCKED), registered.
- Reset asserted mid-frame returns immediately to the reset state above.
- After reset, the first valid word with in_sync=1 restarts framing.

Test Plan (WIDTH=8):
1. Reset, then valid words A1(sync),B2,C3,D4 on consecutive cycles:
   - out0..3 = A1,B2,C3,D4.
   - out_valid high exactly one cycle after D4 sampled.
   - frame_count = 1, locked = 1, {s1,s0} = 0.
2. Same frame with in_valid=0 gaps of 1-3 cycles between words:
   - identical outputs; out_valid only after D4.
   - {s1,s0} constant during gaps.
3. Frame 11,22,33,44, then 55(sync),66, then 77(sync),88,99,AA:
   - sync_err pulses once at the 77 word.
   - out0..3 stay 11,22,33,44 until they become 77,88,99,AA.
   - frame_count = 2.
4. Locked at slot 0, valid word 5A with in_sync=0:
   - sync_err one pulse, locked = 0, word discarded.
   - Following non-sync words ignored; the next sync word relocks.
5. 256 consecutive complete frames with CNT_W=8:
   - frame_count returns to 0; out_valid pulses every 4th cycle.
6. Assert reset after two words of a frame:
   - all outputs 0, locked = 0, {s1,s0} = 0.
   - A fresh frame after release decodes correctly.
